// File: rtl/axi_burst_copy_pkg.sv
// Shared types, AXI constants and the 4 KB boundary helper for the burst-copy master.
// The optional read-back verify pass (AXI_BURST_COPY_VERIFY_EN) adds two states here.
package axi_burst_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP
`ifdef AXI_BURST_COPY_VERIFY_EN
        ,
        ST_VF_ADDR,
        ST_VF_DATA
`endif
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // True when a burst starting at this page offset runs past the end of its 4 KB page.
    function automatic logic crosses4k(input logic [11:0] offset,
                                       input logic [7:0]  beatsMinusOne,
                                       input int unsigned bytesPerBeat);
        logic [31:0] endByte;
        endByte = {20'd0, offset} + ({24'd0, beatsMinusOne} + 32'd1) * bytesPerBeat;
        return endByte > 32'd4096;
    endfunction

endpackage

// File: rtl/axi_burst_copy_buf.sv
// Word buffer holding one burst between the read and write phases.
// One synchronous write port, one combinational read port; contents are not reset.
module axi_burst_copy_buf
    import axi_burst_copy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_burst_copy.sv
// Single-outstanding AXI4 master copying one INCR burst from src_addr to dst_addr.
// Define AXI_BURST_COPY_VERIFY_EN to add a read-back compare of the destination.
module axi_burst_copy
    import axi_burst_copy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [7:0]            len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int         IDX_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [7:0]            len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  bufWe;
    logic [DATA_WIDTH-1:0] bufRdata;
    logic                  idxAtLen;
    logic                  reject;
    logic                  beatError;
    logic                  arPhase;
    logic                  rPhase;
    logic                  unusedInputs;

    assign idxAtLen = (8'(idx_q) == len_q);

    assign reject = ({1'b0, len} >= 9'(MAX_BURST))
                 || crosses4k(src_addr[11:0], len, STRB_WIDTH)
                 || crosses4k(dst_addr[11:0], len, STRB_WIDTH);

    assign unusedInputs = ^{m_axi_bid, m_axi_rid};

    axi_burst_copy_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_BURST),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (bufWe),
        .waddr_i (idx_q),
        .wdata_i (m_axi_rdata),
        .raddr_i (idx_q),
        .rdata_o (bufRdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        bufWe     = 1'b0;
        beatError = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    idx_d   = '0;
                    error_d = 1'b0;
                    if (reject) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_RD_ADDR;
                    end
                end
            end

            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = ST_RD_DATA;
                end
            end

            // A burst whose rlast disagrees with the requested length is treated as failed.
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    bufWe     = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                    beatError = error_q | (m_axi_rresp != RESP_OKAY);
                    if (m_axi_rlast || idxAtLen) begin
                        idx_d = '0;
                        if (m_axi_rlast != idxAtLen) begin
                            beatError = 1'b1;
                        end
                        if (beatError) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WR_ADDR;
                        end
                    end
                    error_d = beatError;
                end
            end

            ST_WR_ADDR: begin
                if (m_axi_awready) begin
                    state_d = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (m_axi_wready) begin
                    if (idxAtLen) begin
                        idx_d   = '0;
                        state_d = ST_WR_RESP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    beatError = error_q | (m_axi_bresp != RESP_OKAY);
                    error_d   = beatError;
`ifdef AXI_BURST_COPY_VERIFY_EN
                    if (beatError) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_VF_ADDR;
                    end
`else
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end

`ifdef AXI_BURST_COPY_VERIFY_EN
            ST_VF_ADDR: begin
                if (m_axi_arready) begin
                    state_d = ST_VF_DATA;
                end
            end

            ST_VF_DATA: begin
                if (m_axi_rvalid) begin
                    idx_d     = idx_q + IDX_W'(1);
                    beatError = error_q | (m_axi_rresp != RESP_OKAY) | (m_axi_rdata != bufRdata);
                    if (m_axi_rlast || idxAtLen) begin
                        idx_d = '0;
                        if (m_axi_rlast != idxAtLen) begin
                            beatError = 1'b1;
                        end
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    error_d = beatError;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef AXI_BURST_COPY_VERIFY_EN
    assign arPhase      = (state_q == ST_RD_ADDR) || (state_q == ST_VF_ADDR);
    assign rPhase       = (state_q == ST_RD_DATA) || (state_q == ST_VF_DATA);
    assign m_axi_araddr = (state_q == ST_VF_ADDR) ? dst_q : src_q;
`else
    assign arPhase      = (state_q == ST_RD_ADDR);
    assign rPhase       = (state_q == ST_RD_DATA);
    assign m_axi_araddr = src_q;
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_DEFAULT;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arPhase;
    assign m_axi_rready  = rPhase;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = dst_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_DEFAULT;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == ST_WR_ADDR);

    assign m_axi_wdata  = bufRdata;
    assign m_axi_wstrb  = '1;
    assign m_axi_wvalid = (state_q == ST_WR_DATA);
    assign m_axi_wlast  = (state_q == ST_WR_DATA) && idxAtLen;

    assign m_axi_bready = (state_q == ST_WR_RESP);

endmodule

// File: tb/tb_axi_burst_copy.sv
// Bench for axi_burst_copy: behavioural AXI RAM slave with optional random backpressure,
// protocol stability monitor, and an arithmetic model of expected copy outcome.
module tb_axi_burst_copy;

    localparam int MEM_WORDS = 16384;
`ifdef AXI_BURST_COPY_VERIFY_EN
    localparam int EXP_AR   = 2;
    localparam int EXP_LAT0 = 8;
`else
    localparam int EXP_AR   = 1;
    localparam int EXP_LAT0 = 6;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  len;
    logic        busy, done, error;

    logic [0:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    assign m_axi_bid = 1'b0;
    assign m_axi_rid = 1'b0;

    always #5 clk = ~clk;

    axi_burst_copy dut (
        .clk(clk), .rst(rst),
        .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .error(error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Preloaded source image (written only by the stimulus) and a separate write image
    // (written only by the slave) so each array has a single writer.
    logic [31:0] mem   [MEM_WORDS];
    logic [31:0] wrMem [MEM_WORDS];
    bit          wrValid [MEM_WORDS];

    bit stallMode, forceWLow;
    int injectBeat;

    int unsigned arCount = 0, awCount = 0, rBeatCount = 0, wBeatCount = 0;
    int unsigned slaveErrors = 0, protoErrors = 0;
    bit  rdAct, wrAct, bPend;
    int  rWord, rLen, rBeat, wWord, wLen, wBeat;
    logic [7:0] lastArLen, lastAwLen;
    logic [15:0] lastAraddr, lastAwaddr;
    logic [2:0] lastArSize, lastAwSize, lastArProt;
    logic [1:0] lastArBurst, lastAwBurst;
    logic [3:0] lastArCache, lastAwCache, lastWstrb;
    logic       lastArLock, lastArId;

    function automatic logic [31:0] slaveRead(input int w);
        return wrValid[w & (MEM_WORDS - 1)] ? wrMem[w & (MEM_WORDS - 1)] : mem[w & (MEM_WORDS - 1)];
    endfunction

    function automatic logic [31:0] dstWord(input int byteAddr);
        int w;
        w = (byteAddr >> 2) & (MEM_WORDS - 1);
        return wrValid[w] ? wrMem[w] : 32'hDEAD_BEEF;
    endfunction

    // Behavioural AXI RAM slave; W is processed before AW so a W beat that races
    // its own address handshake is flagged.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rlast <= 1'b0;
            m_axi_rresp   <= 2'b00; m_axi_rdata <= '0;
            m_axi_awready <= 1'b0; m_axi_wready <= 1'b0;
            m_axi_bvalid  <= 1'b0; m_axi_bresp <= 2'b00;
            rdAct = 1'b0; wrAct = 1'b0; bPend = 1'b0;
        end else begin
            if (m_axi_rvalid && m_axi_rready) begin
                rBeatCount++;
                if (rBeat == rLen) rdAct = 1'b0;
                rBeat++;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                arCount++;
                rdAct = 1'b1; rWord = int'(m_axi_araddr >> 2); rLen = int'(m_axi_arlen); rBeat = 0;
                lastArLen = m_axi_arlen; lastAraddr = m_axi_araddr; lastArSize = m_axi_arsize;
                lastArBurst = m_axi_arburst; lastArCache = m_axi_arcache; lastArLock = m_axi_arlock;
                lastArProt = m_axi_arprot; lastArId = m_axi_arid;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                wBeatCount++;
                lastWstrb = m_axi_wstrb;
                if (!wrAct) begin
                    slaveErrors++;
                end else begin
                    wrMem[(wWord + wBeat) & (MEM_WORDS - 1)]   = m_axi_wdata;
                    wrValid[(wWord + wBeat) & (MEM_WORDS - 1)] = 1'b1;
                    if (m_axi_wlast != (wBeat == wLen)) slaveErrors++;
                    if (wBeat == wLen) begin
                        wrAct = 1'b0; bPend = 1'b1;
                    end
                    wBeat++;
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                awCount++;
                wrAct = 1'b1; wWord = int'(m_axi_awaddr >> 2); wLen = int'(m_axi_awlen); wBeat = 0;
                lastAwLen = m_axi_awlen; lastAwaddr = m_axi_awaddr; lastAwSize = m_axi_awsize;
                lastAwBurst = m_axi_awburst; lastAwCache = m_axi_awcache;
            end
            if (m_axi_bvalid && m_axi_bready) bPend = 1'b0;

            if (!(m_axi_rvalid && !m_axi_rready)) begin
                m_axi_rvalid <= rdAct && (!stallMode || $urandom_range(0, 1) == 1);
                m_axi_rdata  <= slaveRead(rWord + rBeat);
                m_axi_rlast  <= (rBeat == rLen);
                m_axi_rresp  <= (rBeat == injectBeat) ? 2'b10 : 2'b00;
            end
            if (!(m_axi_bvalid && !m_axi_bready)) begin
                m_axi_bvalid <= bPend && (!stallMode || $urandom_range(0, 1) == 1);
            end
            m_axi_arready <= !stallMode || $urandom_range(0, 1) == 1;
            m_axi_awready <= !stallMode || $urandom_range(0, 1) == 1;
            m_axi_wready  <= !forceWLow && (!stallMode || $urandom_range(0, 1) == 1);
        end
    end

    // Valid and payload must hold while the slave stalls a handshake.
    bit          pArV, pArR, pAwV, pAwR, pWV, pWR, pWl;
    logic [15:0] pAra, pAwa;
    logic [7:0]  pArl, pAwl;
    logic [31:0] pWd;
    always @(posedge clk) begin
        if (!rst) begin
            if (pArV && !pArR && !(m_axi_arvalid && m_axi_araddr == pAra && m_axi_arlen == pArl)) protoErrors++;
            if (pAwV && !pAwR && !(m_axi_awvalid && m_axi_awaddr == pAwa && m_axi_awlen == pAwl)) protoErrors++;
            if (pWV && !pWR && !(m_axi_wvalid && m_axi_wdata == pWd && m_axi_wlast == pWl)) protoErrors++;
        end
        pArV = !rst && m_axi_arvalid; pArR = m_axi_arready; pAra = m_axi_araddr; pArl = m_axi_arlen;
        pAwV = !rst && m_axi_awvalid; pAwR = m_axi_awready; pAwa = m_axi_awaddr; pAwl = m_axi_awlen;
        pWV  = !rst && m_axi_wvalid;  pWR  = m_axi_wready;  pWd  = m_axi_wdata;  pWl  = m_axi_wlast;
    end

    int checks = 0, failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pulses start for one cycle; cycles counts negedges after the accepting edge until done.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                                 input int extraAt, output int cycles, output bit busyFirst,
                                 output bit busyAtDone, output bit timedOut);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        cycles = 0; timedOut = 1'b1; busyFirst = 1'b0; busyAtDone = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start = (n == extraAt);
            if (n == extraAt) begin
                src_addr = 16'h2000; dst_addr = 16'h9000; len = 8'd1;
            end
            if (n == 1) busyFirst = busy;
            if (done) begin
                cycles = n; busyAtDone = busy; timedOut = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc, sI, dI, l, arBase, awBase, rBase, wBase, pBase, sBase;
        bit bF, bD, to, expErr, sawW;
        logic [31:0] expWords [16];

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        stallMode = 1'b0; forceWLow = 1'b0; injectBeat = -1;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA5A5_0000 ^ 32'(i);

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_arvalid", m_axi_arvalid, 0);
        checkOutput("rst_awvalid", m_axi_awvalid, 0);
        checkOutput("rst_wvalid", m_axi_wvalid, 0);
        checkOutput("rst_rready", m_axi_rready, 0);
        checkOutput("rst_bready", m_axi_bready, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed copy of four known words, zero-wait slave.
        for (int k = 0; k < 4; k++) mem[(16'h0100 >> 2) + k] = 32'h11 * 32'(k + 1);
        wBase = int'(wBeatCount); sBase = int'(slaveErrors);
        applyStimulus(16'h0100, 16'h0400, 8'd3, 0, cyc, bF, bD, to);
        checkOutput("t1_timeout", to, 0);
        checkOutput("t1_error", error, 0);
        checkOutput("t1_busy_first", bF, 1);
        checkOutput("t1_busy_at_done", bD, 0);
        checkOutput("t1_arlen", lastArLen, 3);
        checkOutput("t1_araddr", lastAraddr, 16'h0100);
        checkOutput("t1_awlen", lastAwLen, 3);
        checkOutput("t1_awaddr", lastAwaddr, 16'h0400);
        checkOutput("t1_fixed_ar", {lastArSize, lastArBurst, lastArCache, lastArLock, lastArProt, lastArId},
                    {3'd2, 2'b01, 4'b0011, 1'b0, 3'd0, 1'b0});
        checkOutput("t1_fixed_aw", {lastAwSize, lastAwBurst, lastAwCache}, {3'd2, 2'b01, 4'b0011});
        checkOutput("t1_wstrb", lastWstrb, 4'hF);
        checkOutput("t1_wbeats", int'(wBeatCount) - wBase, 4);
        checkOutput("t1_wlast_order", int'(slaveErrors) - sBase, 0);
        for (int k = 0; k < 4; k++) checkOutput("t1_dst_word", dstWord(16'h0400 + 4 * k), 32'h11 * 32'(k + 1));
        @(negedge clk);
        checkOutput("t1_done_pulse", done, 0);

        // Single-beat copy latency.
        rBase = int'(rBeatCount); wBase = int'(wBeatCount);
        applyStimulus(16'h0140, 16'h0440, 8'd0, 0, cyc, bF, bD, to);
        checkOutput("t2_timeout", to, 0);
        checkOutput("t2_latency", cyc, EXP_LAT0);
        checkOutput("t2_rbeats", int'(rBeatCount) - rBase, EXP_AR);
        checkOutput("t2_wbeats", int'(wBeatCount) - wBase, 1);
        checkOutput("t2_dst_word", dstWord(16'h0440), mem[16'h0140 >> 2]);
        checkOutput("t2_error", error, 0);

        // Randomised copies under 50% backpressure, judged against the arithmetic model.
        stallMode = 1'b1;
        for (int it = 0; it < 4; it++) begin
            l  = (it == 0) ? 15 : int'($urandom_range(0, 15));
            sI = int'($urandom_range(0, 32'h3FFF)) & 32'hFFFC;
            dI = 32'h8000 + it * 32'h1000 + (int'($urandom_range(0, 32'hFFF)) & 32'hFFC);
            for (int k = 0; k <= l; k++) begin
                expWords[k] = $urandom;
                mem[((sI >> 2) + k) & (MEM_WORDS - 1)] = expWords[k];
            end
            expErr = ((sI & 4095) + (l + 1) * 4 > 4096) || ((dI & 4095) + (l + 1) * 4 > 4096);
            arBase = int'(arCount); pBase = int'(protoErrors); sBase = int'(slaveErrors);
            applyStimulus(16'(sI), 16'(dI), 8'(l), (it == 0) ? 2 : 0, cyc, bF, bD, to);
            checkOutput("rnd_timeout", to, 0);
            checkOutput("rnd_error", error, expErr);
            checkOutput("rnd_stable", int'(protoErrors) - pBase, 0);
            checkOutput("rnd_slave_proto", int'(slaveErrors) - sBase, 0);
            checkOutput("rnd_ar_count", int'(arCount) - arBase, expErr ? 0 : EXP_AR);
            if (!expErr) begin
                for (int k = 0; k <= l; k++) checkOutput("rnd_dst_word", dstWord(dI + 4 * k), expWords[k]);
            end
        end
        stallMode = 1'b0;

        // Rejections: 4 KB crossing on either side and over-long bursts.
        arBase = int'(arCount); awBase = int'(awCount);
        applyStimulus(16'h0FF8, 16'h0500, 8'd3, 0, cyc, bF, bD, to);
        checkOutput("x4k_src_latency", cyc, 1);
        checkOutput("x4k_src_error", error, 1);
        checkOutput("x4k_src_busy", bD, 0);
        checkOutput("x4k_src_no_ar", int'(arCount) - arBase, 0);
        applyStimulus(16'h0200, 16'h1FFC, 8'd1, 0, cyc, bF, bD, to);
        checkOutput("x4k_dst_error", error, 1);
        applyStimulus(16'h0200, 16'h0700, 8'd16, 0, cyc, bF, bD, to);
        checkOutput("len16_latency", cyc, 1);
        checkOutput("len16_error", error, 1);
        applyStimulus(16'h0200, 16'h0700, 8'd255, 0, cyc, bF, bD, to);
        checkOutput("len255_error", error, 1);
        checkOutput("reject_no_traffic", int'(arCount) - arBase + int'(awCount) - awBase, 0);

        // Error response on the second read beat skips the write phase.
        injectBeat = 1;
        awBase = int'(awCount); rBase = int'(rBeatCount);
        applyStimulus(16'h0300, 16'h0800, 8'd2, 0, cyc, bF, bD, to);
        checkOutput("rresp_timeout", to, 0);
        checkOutput("rresp_error", error, 1);
        checkOutput("rresp_no_aw", int'(awCount) - awBase, 0);
        checkOutput("rresp_rbeats", int'(rBeatCount) - rBase, 3);
        injectBeat = -1;
        repeat (2) @(negedge clk);
        checkOutput("rresp_error_sticky", error, 1);

        // Burst ending exactly at the page boundary is legal and clears the previous error.
        for (int k = 0; k < 4; k++) mem[(16'h0FF0 >> 2) + k] = 32'hC0DE_0000 + 32'(k);
        applyStimulus(16'h0FF0, 16'h0600, 8'd3, 0, cyc, bF, bD, to);
        checkOutput("edge4k_error", error, 0);
        checkOutput("edge4k_last_word", dstWord(16'h060C), 32'hC0DE_0003);

        // Asynchronous reset while a W beat is stalled.
        forceWLow = 1'b1;
        @(negedge clk);
        src_addr = 16'h0340; dst_addr = 16'h0A00; len = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sawW = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (m_axi_wvalid) begin
                sawW = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rstmid_reached_wdata", sawW, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstmid_wvalid", m_axi_wvalid, 0);
        checkOutput("rstmid_awvalid", m_axi_awvalid, 0);
        checkOutput("rstmid_arvalid", m_axi_arvalid, 0);
        checkOutput("rstmid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; forceWLow = 1'b0;
        @(negedge clk);
        applyStimulus(16'h0380, 16'h0B00, 8'd1, 0, cyc, bF, bD, to);
        checkOutput("rstmid_after_timeout", to, 0);
        checkOutput("rstmid_after_error", error, 0);
        checkOutput("rstmid_after_word0", dstWord(16'h0B00), mem[16'h0380 >> 2]);
        checkOutput("rstmid_after_word1", dstWord(16'h0B04), mem[(16'h0380 >> 2) + 1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_burst_copy.md
Name: axi_burst_copy

Overview:
- Single-outstanding AXI4 master that copies one burst: reads LEN+1 words from SRC_ADDR into a local buffer, then writes them to DST_ADDR.
- Sits directly upstream of the AXI4 RAM slave; drives its full AW/W/B/AR/R channel set.
- Used for on-chip block moves and memory self-test.
- Controlled by a simple start/busy/done CSR-style interface.

Parameters:
- DATA_WIDTH, 32, AXI data width; multiple of 8, power-of-two bytes.
- ADDR_WIDTH, 16, AXI byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, byte lanes.
- ID_WIDTH, 1, AXI ID width; all transactions use ID 0.
- MAX_BURST, 16, buffer depth in words and largest legal burst; power of two, ≤256.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_WIDTH  read start byte address; word aligned
- dst_addr  in  ADDR_WIDTH  write start byte address; word aligned
- len  in  8  beats minus one
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at completion, with or without error
- error  out  1  sticky status of last copy; cleared on next accepted start
- m_axi_aw*  out  AXI4 write address: awid, awaddr, awlen[8], awsize[3], awburst[2], awlock, awcache[4], awprot[3], awvalid; awready in
- m_axi_w*  out  wdata, wstrb, wlast, wvalid; wready in
- m_axi_b*  in  bid, bresp[2], bvalid; bready out
- m_axi_ar*  out  same field set as AW; arready in
- m_axi_r*  in  rid, rdata, rresp[2], rlast, rvalid; rready out

Behaviour:
- Reset values (async): all valid/ready outputs 0, busy 0, done 0, error 0, state IDLE, buffer contents don't-care.
- Fixed fields: size = clog2(STRB_WIDTH), burst = INCR (2'b01), lock 0, cache 4'b0011, prot 0, id 0, wstrb all ones.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - start=1 latches addresses and len, clears error, sets busy.
  - Rejection check: len ≥ MAX_BURST, or either burst crosses a 4 KB boundary (addr[11:0] + (len+1)*STRB_WIDTH > 4096).
  - Rejected: no bus traffic; error=1 and done pulse the next cycle; return to IDLE.
  - Accepted: go to RD_ADDR; arvalid rises the cycle after start.
- RD_ADDR: arvalid held with stable araddr/arlen until arready; then RD_DATA.
- RD_DATA:
  - rready=1; each rvalid beat is written to buf[idx]; idx increments.
  - rresp ≠ OKAY sets error.
  - Exit on rlast or idx==len, whichever comes first.
  - If rlast and idx==len disagree, set error.
  - Any error at exit: skip the write phase, done pulse, go to IDLE. Otherwise go to WR_ADDR.
- WR_ADDR: awvalid held until awready; then WR_DATA with idx=0. AW precedes W; no W beat is issued before the AW handshake.
- WR_DATA:
  - wvalid=1, wdata=buf[idx], wlast=(idx==len).
  - Advance on wready; after the last beat go to WR_RESP.
  - wvalid must not drop once asserted until the handshake completes.
- WR_RESP: bready=1; on bvalid, bresp ≠ OKAY sets error; done pulse; go to IDLE.
- done asserts exactly one cycle, coincident with busy falling.
- start while busy is ignored.
- Minimum latency for len=0 with a zero-wait slave: 6 cycles from start to done.
- Reset mid-operation abandons any AXI transaction; the system resets the slave together with this block.
- len=255 is always rejected when MAX_BURST ≤ 255.

Optional Feature:
- Macro AXI_BURST_COPY_VERIFY_EN.
- Defined:
  - After WR_RESP with no error, add states VF_ADDR and VF_DATA, which read DST_ADDR back using the same AR rules.
  - Each returned beat is compared to buf[idx]; any mismatch or non-OKAY rresp sets error.
  - done pulses after the verify burst completes.
- Undefined: states and comparator absent; done follows WR_RESP directly.

Decomposition:
- Package axi_burst_copy_pkg holds:
  - state encoding type;
  - AXI constants: BURST_INCR, RESP_OKAY, CACHE_DEFAULT;
  - the 4 KB boundary-check function.
- One sub-module, axi_burst_copy_buf: MAX_BURST×DATA_WIDTH register array, single synchronous write port, asynchronous read port.

Test Plan:
- src=0x0100, dst=0x0400, len=3, RAM preloaded 0x11,0x22,0x33,0x44 -> arlen=3, awlen=3, wlast on 4th beat, dst holds the same words, done=1 and error=0.
- len=0, zero-wait slave -> exactly one R and one W beat; done 6 cycles after start.
- Random rvalid/wready/awready/bvalid backpressure at 50%, len=15 -> data intact; valid and payload stable while stalled.
- src=0x0FF8, len=3 (crosses 4 KB) -> no ARVALID ever; error=1, done one cycle after start.
- Slave returns rresp=2'b10 on beat 1 of len=2 -> no AW issued; error=1, done pulses.
- Reset asserted during WR_DATA -> all valids and busy drop immediately (async); next start=1 with len=1 completes normally with error=0.
